// File: rtl/grf_scoreboard_if.sv
// grf_scoreboard_if
// Groups the D-stage instruction description and the hazard decisions that
// flow between the pipeline control and the GRF scoreboard.
//   master : pipeline side, drives the D-stage fields, reads the decisions
//   slave  : scoreboard side, reads the D-stage fields, drives the decisions
// D fields : d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
//            d_md_start, d_md_div, d_md_use
// Decisions: stall, fwd_rs, fwd_rt (00 GRF, 01 M, 10 E), md_busy
interface grf_scoreboard_if;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_dst;
  logic [1:0] d_tnew;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs, fwd_rt, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs, fwd_rt, md_busy
  );
endinterface

// File: rtl/grf_scoreboard.sv
// grf_scoreboard
// Hazard controller for the five-stage pipeline's register file. Tracks the
// destination register and remaining result latency (tnew) of the
// instructions in E, M and W, and the multiply/divide busy window. Each
// cycle it decides whether the D instruction stalls and where its rs/rt
// operands come from.
// Ports:
//   clk   : pipeline clock
//   reset : synchronous active-high, clears all slots and the md counter
//   bus   : grf_scoreboard_if.slave (D-stage fields in, stall/fwd/md_busy out)
module grf_scoreboard #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  grf_scoreboard_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
  } slot_t;

  slot_t      e_reg, m_reg, w_reg;
  logic [3:0] cnt_reg;

  logic [4:0] op_reg_num [2];
  logic [1:0] op_tuse    [2];
  logic       op_stall   [2];
  logic [1:0] op_fwd     [2];
  logic       stall_md;
  logic       accept;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  assign op_reg_num[0] = bus.d_rs;
  assign op_reg_num[1] = bus.d_rt;
  assign op_tuse[0]    = bus.d_tuse_rs;
  assign op_tuse[1]    = bus.d_tuse_rt;

  // Per-operand resolution: the youngest matching slot (E, then M, then W)
  // alone decides. A W match never forwards because the GRF bypasses it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    always_comb begin
      logic       hit;
      logic [1:0] tn;
      logic [1:0] src;
      hit = 1'b0;
      tn  = 2'd0;
      src = 2'b00;
      op_stall[gi] = 1'b0;
      op_fwd[gi]   = 2'b00;
      if (op_tuse[gi] != 2'd3 && op_reg_num[gi] != 5'd0) begin
        if (e_reg.valid && e_reg.dst == op_reg_num[gi]) begin
          hit = 1'b1; tn = e_reg.tnew; src = 2'b10;
        end else if (m_reg.valid && m_reg.dst == op_reg_num[gi]) begin
          hit = 1'b1; tn = m_reg.tnew; src = 2'b01;
        end else if (w_reg.valid && w_reg.dst == op_reg_num[gi]) begin
          hit = 1'b1; tn = w_reg.tnew; src = 2'b00;
        end
        if (hit) begin
          op_stall[gi] = (tn > op_tuse[gi]);
          // A match still in flight (tn > 0) without a stall is picked up
          // later by the E/M forwarding of the downstream stages.
          op_fwd[gi]   = (tn == 2'd0) ? src : 2'b00;
        end
      end
    end
  end

  assign stall_md    = bus.d_valid & bus.d_md_use & (cnt_reg != 4'd0);
  assign bus.stall   = bus.d_valid & (op_stall[0] | op_stall[1] | stall_md);
  assign bus.fwd_rs  = op_fwd[0];
  assign bus.fwd_rt  = op_fwd[1];
  assign bus.md_busy = (cnt_reg != 4'd0);
  assign accept      = bus.d_valid & ~bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_reg   <= '0;
      m_reg   <= '0;
      w_reg   <= '0;
      cnt_reg <= 4'd0;
    end else begin
      w_reg <= '{valid: m_reg.valid, dst: m_reg.dst, tnew: sat_dec(m_reg.tnew)};
      m_reg <= '{valid: e_reg.valid, dst: e_reg.dst, tnew: sat_dec(e_reg.tnew)};
      // Writes to $0 are never tracked, so they can never match.
      if (accept && bus.d_dst != 5'd0)
        e_reg <= '{valid: 1'b1, dst: bus.d_dst, tnew: bus.d_tnew};
      else
        e_reg <= '0;

      if (accept && bus.d_md_start)
        cnt_reg <= bus.d_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      else if (cnt_reg != 4'd0)
        cnt_reg <= cnt_reg - 4'd1;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard
// Directed hazard scenarios followed by randomized traffic, all checked
// against a model that tracks each issued instruction by the cycle it
// entered E and derives stage/latency from its age.
module tb_grf_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grf_scoreboard_if bus ();

  grf_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;      // index of the current cycle
  int md_free = 0;  // first cycle in which the md unit is idle again

  typedef struct {
    int issue;  // cycle in which the instruction sat in E
    int dst;
    int tnew;
  } rec_t;
  rec_t q[$];

  // Reference: find the youngest in-flight writer of r (age 0=E, 1=M, 2=W).
  function automatic void model_op(input int r, input int tuse,
                                   output logic s, output logic [1:0] f);
    int best_age;
    int tn;
    s = 1'b0;
    f = 2'b00;
    best_age = 99;
    tn = 0;
    if (tuse == 3 || r == 0) return;
    foreach (q[i]) begin
      int age;
      age = cyc - q[i].issue;
      if (age >= 0 && age <= 2 && q[i].dst == r && age < best_age) begin
        best_age = age;
        tn = q[i].tnew - age;
        if (tn < 0) tn = 0;
      end
    end
    if (best_age == 99) return;
    s = (tn > tuse);
    if (tn == 0) f = (best_age == 0) ? 2'b10 : (best_age == 1) ? 2'b01 : 2'b00;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_d(input logic v, input int rs, input int rt, input int tu_rs,
                       input int tu_rt, input int dst, input int tnew,
                       input logic mds, input logic mdd, input logic mdu);
    bus.d_valid    = v;
    bus.d_rs       = 5'(rs);
    bus.d_rt       = 5'(rt);
    bus.d_tuse_rs  = 2'(tu_rs);
    bus.d_tuse_rt  = 2'(tu_rt);
    bus.d_dst      = 5'(dst);
    bus.d_tnew     = 2'(tnew);
    bus.d_md_start = mds;
    bus.d_md_div   = mdd;
    bus.d_md_use   = mdu;
    #1;
  endtask

  task automatic rand_d();
    logic mds;
    mds = ($urandom_range(0, 7) == 0);
    set_d($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2), mds, $urandom_range(0, 1),
          mds | ($urandom_range(0, 5) == 0));
  endtask

  // Constant expectations for directed steps.
  task automatic expect_now(input string tag, input logic st, input logic [1:0] frs,
                            input logic [1:0] frt);
    check({tag, ".stall"}, bus.stall, st);
    check({tag, ".fwd_rs"}, bus.fwd_rs, frs);
    check({tag, ".fwd_rt"}, bus.fwd_rt, frt);
  endtask

  // Compare against the model, then advance one clock edge.
  task automatic tick(input string tag);
    logic s_rs, s_rt, s_md, st, busy;
    logic [1:0] f_rs, f_rt;
    model_op(bus.d_rs, bus.d_tuse_rs, s_rs, f_rs);
    model_op(bus.d_rt, bus.d_tuse_rt, s_rt, f_rt);
    busy = (cyc < md_free);
    s_md = bus.d_valid & bus.d_md_use & busy;
    st = bus.d_valid & (s_rs | s_rt | s_md);
    check({tag, ".m_stall"}, bus.stall, st);
    check({tag, ".m_fwd_rs"}, bus.fwd_rs, f_rs);
    check({tag, ".m_fwd_rt"}, bus.fwd_rt, f_rt);
    check({tag, ".m_md_busy"}, bus.md_busy, busy);
    $display("[%0d] %s v=%0d rs=%0d rt=%0d dst=%0d stall=%0d fwd_rs=%0d fwd_rt=%0d md_busy=%0d",
             cyc, tag, bus.d_valid, bus.d_rs, bus.d_rt, bus.d_dst, bus.stall,
             bus.fwd_rs, bus.fwd_rt, bus.md_busy);
    @(posedge clk);
    if (bus.d_valid && !st) begin
      if (bus.d_dst != 0) q.push_back('{cyc + 1, int'(bus.d_dst), int'(bus.d_tnew)});
      if (bus.d_md_start) md_free = cyc + 1 + (bus.d_md_div ? 10 : 5);
    end
    cyc++;
    while (q.size() > 0 && cyc - q[0].issue > 2) void'(q.pop_front());
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rand_d();
    @(posedge clk);
    q.delete();
    md_free = 0;
    cyc++;
    #1;
    reset = 1'b0;
    rand_d();
    $display("[%0d] reset released", cyc);
  endtask

  initial begin
    set_d(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    do_reset();
    expect_now("reset", 1'b0, 2'b00, 2'b00);
    check("reset.md_busy", bus.md_busy, 1'b0);
    tick("reset_rand");

    // Load-use, consumer in E: one stall cycle.
    set_d(1, 0, 0, 3, 3, 8, 2, 0, 0, 0); tick("lw8");
    set_d(1, 8, 1, 1, 1, 9, 1, 0, 0, 0);
    expect_now("ldu1_a", 1'b1, 2'b00, 2'b00); tick("addu9");
    expect_now("ldu1_b", 1'b0, 2'b00, 2'b00); tick("addu9");

    // Load-use, consumer in D (branch): two stall cycles.
    set_d(1, 0, 0, 3, 3, 8, 2, 0, 0, 0); tick("lw8");
    set_d(1, 8, 0, 0, 3, 0, 0, 0, 0, 0);
    expect_now("ldu0_a", 1'b1, 2'b00, 2'b00); tick("beq8");
    expect_now("ldu0_b", 1'b1, 2'b00, 2'b00); tick("beq8");
    expect_now("ldu0_c", 1'b0, 2'b00, 2'b00); tick("beq8");

    // lui result forwarded from E, then from M.
    set_d(1, 0, 0, 3, 3, 5, 0, 0, 0, 0); tick("lui5");
    set_d(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
    expect_now("lui_e", 1'b0, 2'b10, 2'b10); tick("beq5");
    expect_now("lui_m", 1'b0, 2'b01, 2'b01); tick("beq5");

    // Two writers of $3: youngest (addu in E) decides.
    set_d(1, 0, 0, 3, 3, 3, 2, 0, 0, 0); tick("lw3");
    set_d(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); tick("addu3");
    set_d(1, 29, 3, 1, 2, 0, 0, 0, 0, 0);
    expect_now("youngest", 1'b0, 2'b00, 2'b00); tick("sw3");

    // div busy window: mflo waits exactly 10 cycles.
    set_d(1, 4, 5, 1, 1, 0, 0, 1, 1, 1); tick("div");
    set_d(1, 0, 0, 3, 3, 2, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      check("div_win.stall", bus.stall, 1'b1);
      check("div_win.md_busy", bus.md_busy, 1'b1);
      tick("mflo");
    end
    check("div_done.stall", bus.stall, 1'b0);
    check("div_done.md_busy", bus.md_busy, 1'b0);
    tick("mflo");

    // Non-md instruction flows freely while the unit is busy.
    set_d(1, 6, 7, 1, 1, 0, 0, 1, 0, 1); tick("mult");
    set_d(1, 6, 7, 1, 1, 10, 1, 0, 0, 0);
    check("md_free_alu.stall", bus.stall, 1'b0);
    check("md_free_alu.md_busy", bus.md_busy, 1'b1);
    tick("addu10");
    set_d(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("bubble");

    // Reset mid-operation with cnt = 7 and all slots valid.
    set_d(1, 0, 0, 3, 3, 0, 0, 1, 1, 1); tick("div");
    set_d(1, 0, 0, 3, 3, 8, 2, 0, 0, 0); tick("lw8");
    set_d(1, 0, 0, 3, 3, 9, 2, 0, 0, 0); tick("lw9");
    set_d(1, 0, 0, 3, 3, 10, 2, 0, 0, 0); tick("lw10");
    check("pre_reset.md_busy", bus.md_busy, 1'b1);
    do_reset();
    set_d(1, 9, 10, 0, 0, 0, 0, 0, 0, 1);
    expect_now("mid_reset", 1'b0, 2'b00, 2'b00);
    check("mid_reset.md_busy", bus.md_busy, 1'b0);
    tick("post_reset");

    // Randomized traffic on a small register set to force frequent matches.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else rand_d();
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Hazard controller for the five-stage pipeline's general register file. It tracks the destination register and remaining result latency (Tnew) of every instruction in E, M and W. From that state it decides each cycle whether the D-stage instruction must stall and which stage feeds its rs/rt operands. It also sequences the multiply/divide unit busy window, so HI/LO-using instructions wait until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu, counted from the cycle the instruction occupies E
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- d_valid  input  1  D holds a real instruction (0 = bubble)
- d_rs, d_rt  input  5  source register numbers of D instruction
- d_tuse_rs, d_tuse_rt  input  2  cycles until operand is consumed (0 = used in D, 1 = E, 2 = M, 3 = not used)
- d_dst  input  5  destination register (0 = no write)
- d_tnew  input  2  cycles after entering E until result is forwardable (0 = lui/jal, 1 = ALU, 2 = load)
- d_md_start  input  1  D instruction is mult/multu/div/divu
- d_md_div  input  1  with d_md_start: 1 = div, 0 = mult
- d_md_use  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- stall  output  1  freeze PC and F/D register, inject bubble into E
- fwd_rs, fwd_rt  output  2  D operand source: 00 GRF (includes W via GRF internal bypass), 01 M, 10 E
- md_busy  output  1  busy counter non-zero

## Operation
- State: three stage slots E, M, W, each {valid, dst[4:0], tnew[1:0]}; md counter cnt[3:0].
- Each edge (not reset): W <= M with tnew = sat(tnew-1); M <= E with tnew = sat(tnew-1); E <= D entry if d_valid & !stall & d_dst != 0, else bubble (valid = 0). sat floors at 0.
- Matching per operand r in {rs, rt}: a slot matches when valid & dst == d_r & d_r != 0. Priority is youngest first: E, then M, then W.
- Operand is ignored when d_tuse_r == 3 or d_r == 0: no stall contribution, fwd = 00.
- stall_r = youngest match exists & match.tnew > d_tuse_r.
- fwd_r = 10 if the youngest match is E with tnew 0; 01 if it is M with tnew 0; otherwise 00. No match or a W match gives 00. When the youngest match has tnew > 0 and no stall results, fwd is 00 and downstream E/M forwarding supplies the value.
- stall_md = d_valid & d_md_use & (cnt != 0).
- stall = d_valid & (stall_rs | stall_rt | stall_md). stall, fwd_* and md_busy are combinational from state and D inputs.
- md counter: an accepted D instruction (d_valid & !stall & d_md_start) loads cnt with DIV_CYCLES if d_md_div, else MULT_CYCLES. Otherwise cnt decrements while non-zero. md_busy = (cnt != 0).

## Timing
- Reset: all slots invalid, cnt = 0. The cycle after reset: stall = 0, fwd_rs = fwd_rt = 00, md_busy = 0 for any D input.
- Reset asserted mid-operation, including with cnt non-zero, clears everything at that edge. Reset has priority over all updates.
- Zero-latency decision: stall is valid in the same cycle D inputs are presented.
- A stalled instruction re-evaluates every cycle. It issues on the first cycle stall = 0.
- Load-use: a load enters E with tnew 2. A dependent instruction with tuse 1 stalls exactly 1 cycle; with tuse 0 it stalls 2 cycles.
- MD: a mult accepted at edge t gives cnt = 5 for cycles t+1..t+5. md_busy is high for 5 cycles. A D md_use instruction stalls in those cycles and issues in cycle t+6.
- Two slots may match the same register. Only the youngest counts.
- d_dst = 0 never enters the scoreboard. $0 never causes a stall or forward.

## Test plan
- Reset with all D inputs toggling randomly -> stall = 0, fwd = 00, md_busy = 0 on the first post-reset cycle.
- lw $8 issued; next D is addu $9,$8,$1 (tuse_rs 1) -> stall = 1 for 1 cycle, then issue with fwd_rs = 00. beq $8 (tuse 0) -> 2 stall cycles, then fwd_rs = 01 (load in M? no: in W -> 00).
- lui $5 issued (tnew 0); next D beq $5,$5 -> stall = 0, fwd_rs = fwd_rt = 10. One cycle later a similar beq -> fwd = 01.
- addu $3 in E and lw $3 in M; D sw with rt = $3 (tuse 2) -> youngest E (tnew 1) wins, stall = 0.
- div accepted, then mflo in D -> md_busy and stall high for exactly 10 cycles; mflo issues in cycle 11. A non-md instruction in D is not stalled during that window.
- Reset asserted while cnt = 7 and slots valid -> next cycle cnt = 0, stall = 0, all fwd = 00.
